int_vector_ctl: RTL and testbench

INT_VECTOR_CTL -- requirements
Module: int_vector_ctl

---
 rtl/int_vector_ctl.sv | 92 +++++++++
 tb/tb_int_vector_ctl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/int_vector_ctl.sv
// int_vector_ctl: vectored interrupt controller that issues one-cycle PC-load strobes to a CPU core.
// Optional source mask register is enabled by defining INT_MASK_EN.
module int_vector_ctl #(
   parameter int          NSRC       = 4,
   parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'h10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq,
   input  logic            ack,
   input  logic            mask_we,
   input  logic [NSRC-1:0] mask_wd,
   output logic            INT,
   output logic [31:0]     entryPoint,
   output logic            busy,
   output logic [1:0]      cause,
   output logic [NSRC-1:0] pending
);
   typedef enum logic [1:0] {BOOT, IDLE, ISSUE, SERVICE} state_t;
   state_t          r_state, w_state_nxt;
   logic [NSRC-1:0] r_irq_q, w_mask, w_req, w_clr;
   logic [1:0]      w_sel, w_cause_nxt;
   logic [31:0]     w_ep_nxt;
   logic            w_int_nxt, w_busy_nxt;
`ifdef INT_MASK_EN
   logic [NSRC-1:0] r_mask;
   always_ff @(posedge clk)
      if (rst) r_mask <= '1;
      else if (mask_we) r_mask <= mask_wd;
   assign w_mask = r_mask;
`else
   logic w_unused_mask;
   assign w_mask = '1;
   assign w_unused_mask = &{1'b0, mask_we, mask_wd};
`endif
   assign w_req = pending & w_mask;
   // lowest index wins: scan downwards so the last hit is the smallest
   always_comb begin
      w_sel = '0;
      for (int i = NSRC - 1; i >= 0; i--) w_sel = w_req[i] ? 2'(i) : w_sel;
   end
   always_comb begin
      w_state_nxt = r_state;
      w_int_nxt   = 1'b0;
      w_busy_nxt  = busy;
      w_ep_nxt    = entryPoint;
      w_cause_nxt = cause;
      w_clr       = '0;
      case (r_state)
         BOOT: begin
            w_state_nxt = IDLE;
            w_int_nxt   = 1'b1;
            w_ep_nxt    = RESET_VEC;
         end
         IDLE: if (|w_req) begin
            w_state_nxt = ISSUE;
            w_int_nxt   = 1'b1;
            w_busy_nxt  = 1'b1;
            w_cause_nxt = w_sel;
            w_ep_nxt    = VEC_BASE + 32'(w_sel) * VEC_STRIDE;
            w_clr       = NSRC'(1) << w_sel;
         end
         ISSUE: w_state_nxt = SERVICE;
         SERVICE: if (ack) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: w_state_nxt = BOOT;
      endcase
   end
   // a fresh edge on a line being issued this cycle keeps its pending bit set
   always_ff @(posedge clk)
      if (rst) begin
         r_state    <= BOOT;
         INT        <= 1'b0;
         entryPoint <= RESET_VEC;
         busy       <= 1'b0;
         cause      <= '0;
         pending    <= '0;
         r_irq_q    <= '1;
      end else begin
         r_state    <= w_state_nxt;
         INT        <= w_int_nxt;
         entryPoint <= w_ep_nxt;
         busy       <= w_busy_nxt;
         cause      <= w_cause_nxt;
         pending    <= (pending & ~w_clr) | (irq & ~r_irq_q);
         r_irq_q    <= irq;
      end
endmodule

// File: tb/tb_int_vector_ctl.sv
// tb_int_vector_ctl: scoreboard bench; expected INT strobes are queued by stimulus and checked by a monitor.
module tb_int_vector_ctl;
   logic        clk = 1'b0, rst = 1'b1, ack = 1'b0, mask_we = 1'b0;
   logic [3:0]  irq = '0, mask_wd = '0, pending;
   logic        INT, busy;
   logic [31:0] entryPoint;
   logic [1:0]  cause;
   int          cyc = 0, checks = 0, errors = 0;
   typedef struct {logic [31:0] ep; logic [1:0] cs; logic b; int cyc;} exp_t;
   exp_t        sb[$];
   exp_t        e;

   int_vector_ctl dut (
      .clk(clk), .rst(rst), .irq(irq), .ack(ack), .mask_we(mask_we), .mask_wd(mask_wd),
      .INT(INT), .entryPoint(entryPoint), .busy(busy), .cause(cause), .pending(pending)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [31:0] ep, input logic [1:0] cs, input logic b, input int c);
      sb.push_back('{ep, cs, b, c});
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
   endtask

   always @(negedge clk)
      if (INT) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_int: entryPoint %h cause %0d with nothing expected", entryPoint, cause);
         end else begin
            e = sb.pop_front();
            chk("int_cycle", 32'(cyc), 32'(e.cyc));
            chk("int_entryPoint", entryPoint, e.ep);
            chk("int_cause", 32'(cause), 32'(e.cs));
            chk("int_busy", 32'(busy), 32'(e.b));
         end
      end

   initial begin
      tick(3);
      chk("rst_INT", 32'(INT), 0);
      chk("rst_entryPoint", entryPoint, 32'h0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cause", 32'(cause), 0);
      chk("rst_pending", 32'(pending), 0);
      // boot strobe
      rst = 1'b0;
      push(32'h0, 2'd0, 1'b0, cyc + 1);
      tick(2);
      chk("boot_INT_low", 32'(INT), 0);
      chk("boot_busy", 32'(busy), 0);
      // single source 2, ack during ISSUE ignored
      irq = 4'b0100;
      push(32'h120, 2'd2, 1'b1, cyc + 2);
      tick(1);
      chk("lat_pending", 32'(pending), 32'h4);
      chk("lat_INT_low", 32'(INT), 0);
      tick(1);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      chk("issue_ack_ignored_busy", 32'(busy), 1);
      chk("issue_INT_one_cycle", 32'(INT), 0);
      tick(2);
      chk("service_busy", 32'(busy), 1);
      ack_pulse();
      chk("ack_busy_low", 32'(busy), 0);
      irq = '0;
      tick(2);
      // simultaneous sources 1 and 3
      irq = 4'b1010;
      push(32'h110, 2'd1, 1'b1, cyc + 2);
      push(32'h130, 2'd3, 1'b1, cyc + 6);
      tick(4);
      chk("pair_pending", 32'(pending), 32'h8);
      ack_pulse();
      irq = '0;
      tick(3);
      ack_pulse();
      chk("pair_busy_low", 32'(busy), 0);
      chk("pair_pending_clr", 32'(pending), 0);
      tick(1);
      // source 0 rises while source 2 is in service
      irq = 4'b0100;
      push(32'h120, 2'd2, 1'b1, cyc + 2);
      tick(4);
      irq = 4'b0101;
      tick(1);
      chk("nest_pending", 32'(pending), 32'h1);
      chk("nest_busy", 32'(busy), 1);
      push(32'h100, 2'd0, 1'b1, cyc + 2);
      ack_pulse();
      tick(3);
      ack_pulse();
      irq = '0;
      tick(2);
      // new edge on source 0 in the same cycle it is issued
      irq = 4'b0010;
      push(32'h110, 2'd1, 1'b1, cyc + 2);
      tick(1);
      irq = '0;
      tick(1);
      irq = 4'b0001;
      tick(1);
      irq = '0;
      tick(1);
      ack_pulse();
      irq = 4'b0001;
      push(32'h100, 2'd0, 1'b1, cyc + 1);
      tick(1);
      chk("set_wins_pending", 32'(pending), 32'h1);
      tick(2);
      push(32'h100, 2'd0, 1'b1, cyc + 2);
      ack_pulse();
      irq = '0;
      tick(3);
      ack_pulse();
      // mask write
      irq = '0;
      tick(3);
      mask_wd = 4'b1110;
      mask_we = 1'b1;
      tick(1);
      mask_we = 1'b0;
      irq = 4'b0001;
`ifdef INT_MASK_EN
      tick(3);
      chk("masked_pending", 32'(pending), 32'h1);
      chk("masked_busy", 32'(busy), 0);
      mask_wd = 4'b1111;
      mask_we = 1'b1;
      push(32'h100, 2'd0, 1'b1, cyc + 2);
      tick(1);
      mask_we = 1'b0;
      tick(3);
`else
      push(32'h100, 2'd0, 1'b1, cyc + 2);
      tick(3);
      chk("nomask_pending", 32'(pending), 0);
      chk("nomask_busy", 32'(busy), 1);
`endif
      ack_pulse();
      irq = '0;
      tick(2);
      // reset during service
      irq = 4'b0010;
      push(32'h110, 2'd1, 1'b1, cyc + 2);
      tick(2);
      irq = 4'b1010;
      tick(2);
      chk("pre_rst_pending", 32'(pending), 32'h8);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_pending", 32'(pending), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_entryPoint", entryPoint, 32'h0);
      chk("mid_rst_cause", 32'(cause), 0);
      rst = 1'b0;
      push(32'h0, 2'd0, 1'b0, cyc + 1);
      tick(2);
      chk("reboot_no_edge_pending", 32'(pending), 0);
      chk("reboot_busy", 32'(busy), 0);
      irq = '0;
      tick(3);
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
